mux_rr_arbiter16: RTL and testbench

Round-robin arbiter and select controller for a 16:1 single-bit multiplexer. It shares the mux output between 16 requesters: it grants one requester at a time and drives the mux's 4-bit select with that requester's index. A grant is held while the owner keeps requesting, up to a bounded tenure, after which the arbiter preempts the owner if anyone else is waiting. The block sits between the requesting agents and the mux select input.

---
 rtl/mux_rr_arbiter16_if.sv | 33 +++
 rtl/mux_rr_arbiter16.sv | 116 +++++++++++
 tb/tb_mux_rr_arbiter16.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mux_rr_arbiter16_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_rr_arbiter16_if                                                  |
// | Request/grant bundle between the requesters and the 16:1 arbiter.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface mux_rr_arbiter16_if;
   logic [15:0] req;
   logic        en;
   logic [3:0]  sel;
   logic [15:0] gnt;
   logic        gnt_valid;
   logic        preempt;

   modport master (
      output req,
      output en,
      input  sel,
      input  gnt,
      input  gnt_valid,
      input  preempt
   );

   modport slave (
      input  req,
      input  en,
      output sel,
      output gnt,
      output gnt_valid,
      output preempt
   );
endinterface
`default_nettype wire

// File: rtl/mux_rr_arbiter16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_rr_arbiter16                                                     |
// | Round-robin arbiter with bounded tenure driving a 16:1 mux select.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mux_rr_arbiter16 #(
   parameter int HOLD_MAX = 8
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   mux_rr_arbiter16_if.slave  bus
);

   localparam logic [7:0] c_hold_max = 8'(HOLD_MAX);
   localparam logic [7:0] c_hold_sat = 8'hFF;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t      r_state;
   logic [3:0]  r_ptr;
   logic [3:0]  r_sel;
   logic [7:0]  r_hold_cnt;
   logic [15:0] r_gnt;
   logic        r_gnt_valid;
   logic        r_preempt;

   logic [3:0]  w_pick;
   logic [3:0]  w_idx;
   logic        w_found;
   logic        w_any;
   logic        w_owner_req;
   logic        w_others;
   logic        w_can_grant;
   logic        w_expired;

   // Circular scan starting at the pointer; the first hit wins.
   always_comb begin
      w_pick  = r_ptr;
      w_idx   = r_ptr;
      w_found = 1'b0;
      for (int k = 0; k < 16; k++) begin
         w_idx = r_ptr + k[3:0];
         if (!w_found && bus.req[w_idx]) begin
            w_pick  = w_idx;
            w_found = 1'b1;
         end
      end
   end

   assign w_any       = |bus.req;
   assign w_owner_req = bus.req[r_sel];
   assign w_others    = |(bus.req & ~(16'h0001 << r_sel));
   assign w_can_grant = bus.en && w_any;
   assign w_expired   = (r_hold_cnt >= c_hold_max) && bus.en && w_others;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_ptr       <= 4'd0;
         r_sel       <= 4'd0;
         r_hold_cnt  <= 8'd0;
         r_gnt       <= 16'h0000;
         r_gnt_valid <= 1'b0;
         r_preempt   <= 1'b0;
      end else begin
         r_preempt <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_can_grant) begin
                  r_state     <= GRANT;
                  r_gnt       <= 16'h0001 << w_pick;
                  r_sel       <= w_pick;
                  r_gnt_valid <= 1'b1;
                  r_ptr       <= w_pick + 4'd1;
                  r_hold_cnt  <= 8'd1;
               end
            end
            GRANT: begin
               if (!w_owner_req || w_expired) begin
                  // Release and tenure expiry share the handover path.
                  if (w_can_grant) begin
                     r_gnt       <= 16'h0001 << w_pick;
                     r_sel       <= w_pick;
                     r_gnt_valid <= 1'b1;
                     r_ptr       <= w_pick + 4'd1;
                     r_hold_cnt  <= 8'd1;
                     r_preempt   <= w_owner_req;
                  end else begin
                     r_state     <= IDLE;
                     r_gnt       <= 16'h0000;
                     r_gnt_valid <= 1'b0;
                  end
               end else if (r_hold_cnt != c_hold_sat) begin
                  r_hold_cnt <= r_hold_cnt + 8'd1;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_gnt       <= 16'h0000;
               r_gnt_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.sel       = r_sel;
   assign bus.gnt       = r_gnt;
   assign bus.gnt_valid = r_gnt_valid;
   assign bus.preempt   = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mux_rr_arbiter16                                                  |
// | Vector table, corner sequences and random run against a model.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mux_rr_arbiter16;

   localparam int H = 3;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   mux_rr_arbiter16_if bus ();

   mux_rr_arbiter16 #(.HOLD_MAX(H)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: owner index (-1 = none), pointer and tenure as integers.
   int m_owner;
   int m_ptr;
   int m_hold;
   int m_sel;
   int m_pre;

   function automatic int pick(input logic [15:0] r, input int p);
      for (int k = 0; k < 16; k++) begin
         if (r[(p + k) % 16]) return (p + k) % 16;
      end
      return -1;
   endfunction

   task automatic model_grant(input int p);
      m_owner = p;
      m_sel   = p;
      m_ptr   = (p + 1) % 16;
      m_hold  = 1;
   endtask

   task automatic model_step();
      int p;
      logic [15:0] others;
      if (!rst_n) begin
         m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0; m_pre = 0;
         return;
      end
      m_pre = 0;
      p = pick(bus.req, m_ptr);
      if (m_owner < 0) begin
         if (bus.en && p >= 0) model_grant(p);
      end else if (!bus.req[m_owner]) begin
         if (bus.en && p >= 0) model_grant(p);
         else m_owner = -1;
      end else begin
         others = bus.req;
         others[m_owner] = 1'b0;
         if (m_hold >= H && bus.en && others != 16'h0) begin
            model_grant(p);
            m_pre = 1;
         end else if (m_hold < 255) begin
            m_hold = m_hold + 1;
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_model();
      logic [15:0] eg;
      eg = (m_owner < 0) ? 16'h0 : (16'h0001 << m_owner);
      chk("rnd_gnt",   32'(bus.gnt),       32'(eg));
      chk("rnd_sel",   32'(bus.sel),       32'(m_sel));
      chk("rnd_valid", 32'(bus.gnt_valid), 32'(m_owner >= 0));
      chk("rnd_pre",   32'(bus.preempt),   32'(m_pre));
      chk("rnd_onehot", 32'($onehot0(bus.gnt)), 32'd1);
   endtask

   typedef struct {
      logic        rst_n;
      logic        en;
      logic [15:0] req;
      logic [15:0] gnt;
      logic [3:0]  sel;
      logic        valid;
      logic        pre;
   } vec_t;

   vec_t tbl[16];

   initial begin
      logic [15:0] held;
      int n;
      int e;
      int prev;
      checks = 0;
      errors = 0;
      rst_n   = 1'b0;
      bus.en  = 1'b0;
      bus.req = 16'h0;
      m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0; m_pre = 0;

      // Reset, single request, enable gating, suppressed preemption, reset mid-grant.
      tbl[0]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 16'h0010, 16'h0010, 4'd4, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 1'b1, 16'h0000, 16'h0000, 4'd4, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 16'h0003, 16'h0000, 4'd4, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 16'h0003, 16'h0001, 4'd0, 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 16'h0003, 16'h0001, 4'd0, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 16'h0003, 16'h0001, 4'd0, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 16'h0003, 16'h0001, 4'd0, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 16'h0003, 16'h0001, 4'd0, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 1'b1, 16'h0003, 16'h0002, 4'd1, 1'b1, 1'b1};
      tbl[11] = '{1'b1, 1'b1, 16'h0000, 16'h0000, 4'd1, 1'b0, 1'b0};
      tbl[12] = '{1'b1, 1'b1, 16'h0200, 16'h0200, 4'd9, 1'b1, 1'b0};
      tbl[13] = '{1'b0, 1'b1, 16'h0200, 16'h0000, 4'd0, 1'b0, 1'b0};
      tbl[14] = '{1'b1, 1'b1, 16'h0201, 16'h0001, 4'd0, 1'b1, 1'b0};
      tbl[15] = '{1'b1, 1'b1, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0};

      for (int i = 0; i < 16; i++) begin
         rst_n   = tbl[i].rst_n;
         bus.en  = tbl[i].en;
         bus.req = tbl[i].req;
         tick();
         chk($sformatf("tbl%0d_gnt", i),   32'(bus.gnt),       32'(tbl[i].gnt));
         chk($sformatf("tbl%0d_sel", i),   32'(bus.sel),       32'(tbl[i].sel));
         chk($sformatf("tbl%0d_valid", i), 32'(bus.gnt_valid), 32'(tbl[i].valid));
         chk($sformatf("tbl%0d_pre", i),   32'(bus.preempt),   32'(tbl[i].pre));
      end

      // Full-load rotation: three cycles per owner, preempt on each change, wraps after 15.
      rst_n = 1'b0; bus.req = 16'h0; tick(); tick();
      rst_n = 1'b1; bus.en = 1'b1; bus.req = 16'hFFFF;
      for (n = 0; n < 51; n++) begin
         tick();
         chk($sformatf("rot%0d_sel", n), 32'(bus.sel), 32'((n / H) % 16));
         chk($sformatf("rot%0d_pre", n), 32'(bus.preempt), 32'(n > 0 && n % H == 0));
      end

      // Lone holder: no preemption without a competitor, then immediate takeover.
      bus.req = 16'h8000;
      for (n = 0; n < 20; n++) begin
         tick();
         chk("lone_sel", 32'(bus.sel), 32'd15);
         chk("lone_pre", 32'(bus.preempt), 32'd0);
      end
      bus.req = 16'h8002;
      tick();
      chk("lone_take_sel", 32'(bus.sel), 32'd1);
      chk("lone_take_pre", 32'(bus.preempt), 32'd1);

      // Two requesters releasing after two cycles of grant alternate 0,7,0,7.
      rst_n = 1'b0; bus.req = 16'h0; tick();
      rst_n = 1'b1;
      prev = -1;
      for (int k = 0; k < 4; k++) begin
         e = (k % 2) ? 7 : 0;
         held = 16'h0081;
         if (prev >= 0) held[prev] = 1'b0;
         bus.req = held;
         tick();
         chk($sformatf("alt%0d_a", k), 32'(bus.gnt), 32'(16'h0001 << e));
         bus.req = 16'h0081;
         tick();
         chk($sformatf("alt%0d_b", k), 32'(bus.gnt), 32'(16'h0001 << e));
         prev = e;
      end

      // Random traffic against the model.
      held = 16'h0;
      for (n = 0; n < 3000; n++) begin
         rst_n  = ($urandom_range(0, 199) != 0);
         bus.en = ($urandom_range(0, 7) != 0);
         case ($urandom_range(0, 7))
            0: held = 16'($urandom);
            1: held = 16'h0001 << $urandom_range(0, 15);
            2: held = 16'h0;
            3: held = held | (16'h0001 << $urandom_range(0, 15));
            default: held = held;
         endcase
         bus.req = held;
         tick();
         chk_model();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
